// File: rtl/parallel_cpu_1_cpu_ocimem_engine_pkg.sv
// Shared types and jdo field positions for the OCI monitor-RAM engine.
// Imported by the engine, its RAM and the testbench.
package parallel_cpu_1_cpu_ocimem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    C_RD,
    J_RD,
    J_RD_CAP,
    J_WR
  } state_e;

  localparam int JDO_W           = 38;
  localparam int JDO_ADDR_LSB    = 9;
  localparam int JDO_RD_BIT      = 34;
  localparam int JDO_CLR_ERR_BIT = 33;
  localparam int JDO_DATA_MSB    = 34;
  localparam int JDO_DATA_LSB    = 3;

endpackage

// File: rtl/parallel_cpu_1_cpu_ocimem_engine_if.sv
// JTAG debug-slave strobes and CPU debug-memory slave port,
// bundled for the monitor-RAM engine.
interface parallel_cpu_1_cpu_ocimem_engine_if #(
  parameter int ADDR_W = 8
);
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_no_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [31:0]       cpu_writedata;
  logic [3:0]        cpu_byteenable;
  logic              cpu_debugaccess;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;

  modport slave (
    input  jdo,
    input  take_action_ocimem_a,
    input  take_no_action_ocimem_a,
    input  take_action_ocimem_b,
    output MonDReg,
    output monitor_ready,
    output monitor_error,
    input  cpu_address,
    input  cpu_read,
    input  cpu_write,
    input  cpu_writedata,
    input  cpu_byteenable,
    input  cpu_debugaccess,
    output cpu_readdata,
    output cpu_waitrequest
  );

  modport master (
    output jdo,
    output take_action_ocimem_a,
    output take_no_action_ocimem_a,
    output take_action_ocimem_b,
    input  MonDReg,
    input  monitor_ready,
    input  monitor_error,
    output cpu_address,
    output cpu_read,
    output cpu_write,
    output cpu_writedata,
    output cpu_byteenable,
    output cpu_debugaccess,
    input  cpu_readdata,
    input  cpu_waitrequest
  );
endinterface

// File: rtl/parallel_cpu_1_cpu_ocimem_engine_ram.sv
// Single-port 32-bit monitor RAM, byte enables,
// registered one-cycle read data.
module parallel_cpu_1_cpu_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] q_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    q_q <= mem[addr];
  end

  assign q = q_q;

endmodule

// File: rtl/parallel_cpu_1_cpu_ocimem_engine.sv
// Monitor-RAM engine: runs JTAG host accesses and arbitrates
// the single RAM port against the CPU debug slave.
module parallel_cpu_1_cpu_ocimem_engine
  import parallel_cpu_1_cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int RAM_LAT = 1
) (
  input logic clk,
  input logic reset_n,
  parallel_cpu_1_cpu_ocimem_engine_if.slave bus
);

  if (RAM_LAT != 1) begin : g_lat_chk
    $error("parallel_cpu_1_cpu_ocimem_engine: RAM_LAT must be 1");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              jrd_q, jrd_d;
  logic              jwr_q, jwr_d;
  logic              cpu_last_q, cpu_last_d;
  logic              init_q;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;

  logic              wait_o;
  logic              launch, ld_rd, ld_wr;
  logic              cpu_req, jpend;
  logic              unused_jdo;

  assign cpu_req    = bus.cpu_read | bus.cpu_write;
  assign jpend      = jrd_q | jwr_q;
  assign unused_jdo = ^bus.jdo[37:35];

  always_comb begin
    state_d    = state_q;
    mon_a_d    = mon_a_q;
    mon_d_d    = mon_d_q;
    rdata_d    = rdata_q;
    ready_d    = ready_q;
    error_d    = error_q;
    jrd_d      = jrd_q;
    jwr_d      = jwr_q;
    cpu_last_d = cpu_last_q;
    ram_addr   = bus.cpu_address;
    ram_we     = 1'b0;
    ram_be     = bus.cpu_byteenable;
    ram_wdata  = bus.cpu_writedata;
    wait_o     = 1'b1;
    launch     = 1'b0;
    ld_rd      = 1'b0;
    ld_wr      = 1'b0;

    // after a CPU access, a waiting JTAG request goes next
    unique case (state_q)
      IDLE: begin
        wait_o = 1'b0;
        if (!init_q) begin
          wait_o = 1'b1;
        end else if (cpu_req && !(cpu_last_q && jpend)) begin
          cpu_last_d = 1'b1;
          if (bus.cpu_read) begin
            wait_o  = 1'b1;
            state_d = C_RD;
          end else begin
            ram_we = bus.cpu_debugaccess;
          end
        end else begin
          wait_o = cpu_req;
          if (jwr_q) begin
            state_d    = J_WR;
            cpu_last_d = 1'b0;
          end else if (jrd_q) begin
            state_d    = J_RD;
            cpu_last_d = 1'b0;
          end
        end
      end
      C_RD: begin
        wait_o     = 1'b0;
        rdata_d    = ram_q;
        cpu_last_d = 1'b1;
        state_d    = IDLE;
        if (jwr_q) begin
          state_d    = J_WR;
          cpu_last_d = 1'b0;
        end else if (jrd_q) begin
          state_d    = J_RD;
          cpu_last_d = 1'b0;
        end
      end
      J_RD: begin
        ram_addr = mon_a_q;
        state_d  = J_RD_CAP;
      end
      J_RD_CAP: begin
        mon_d_d = ram_q;
        ready_d = 1'b1;
        jrd_d   = 1'b0;
        state_d = IDLE;
      end
      J_WR: begin
        ram_addr  = mon_a_q;
        ram_we    = 1'b1;
        ram_be    = 4'hF;
        ram_wdata = mon_d_q;
        mon_a_d   = mon_a_q + ADDR_W'(1);
        ready_d   = 1'b1;
        jwr_d     = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.take_action_ocimem_b) begin
      mon_d_d = bus.jdo[JDO_DATA_MSB:JDO_DATA_LSB];
      launch  = 1'b1;
      ld_wr   = 1'b1;
    end else if (bus.take_action_ocimem_a) begin
      mon_a_d = bus.jdo[JDO_ADDR_LSB +: ADDR_W];
      if (bus.jdo[JDO_CLR_ERR_BIT]) error_d = 1'b0;
      launch = bus.jdo[JDO_RD_BIT];
      ld_rd  = bus.jdo[JDO_RD_BIT];
    end else if (bus.take_no_action_ocimem_a) begin
      mon_a_d = mon_a_q + ADDR_W'(1);
      launch  = 1'b1;
      ld_rd   = 1'b1;
    end

    // a replacing request aborts a read already presented to the RAM
    if (launch) begin
      ready_d = 1'b0;
      if (jpend) error_d = 1'b1;
      jrd_d = ld_rd;
      jwr_d = ld_wr;
      if (state_q == J_RD) state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mon_a_q    <= '0;
      mon_d_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      jrd_q      <= 1'b0;
      jwr_q      <= 1'b0;
      cpu_last_q <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mon_a_q    <= mon_a_d;
      mon_d_q    <= mon_d_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      jrd_q      <= jrd_d;
      jwr_q      <= jwr_d;
      cpu_last_q <= cpu_last_d;
      init_q     <= 1'b1;
    end
  end

  parallel_cpu_1_cpu_ocimem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  assign bus.MonDReg         = mon_d_q;
  assign bus.monitor_ready   = ready_q;
  assign bus.monitor_error   = error_q;
  assign bus.cpu_readdata    = rdata_q;
  assign bus.cpu_waitrequest = wait_o;

endmodule
